router_pkt_tx: RTL
==================

# router_pkt_tx

Packet transmitter that drives the input port of the 1x3 router; it is the source end of the router's `pkt_valid`/`data_in`/`busy` protocol. A command (destination address and payload length) is accepted, and the payload is collected into an internal 64-byte buffer with a running parity. The block then sends header, payload and parity without gaps, stalling on `busy`. It watches the router `err` output for a bounded window and reports completion with a parity-error status.

## Interface
- `ERR_WAIT`, default 3: cycles spent in the error window after the parity byte is taken (1..15).
- `clk` in 1: clock. All state changes on its rising edge.
- `resetn` in 1: reset. Asynchronous, active-low.
- `start` in 1: command strobe, sampled while `start_ready`=1.
- `req_addr` in 2: destination port 0..2. Value 3 is illegal.
- `req_len` in 6: payload byte count 1..63. Value 0 is illegal.
- `start_ready` out 1: high in IDLE (combinational from state).
- `pl_data` in 8: payload byte.
- `pl_valid` in 1: payload byte valid.
- `pl_ready` out 1: high in LOAD (combinational from state). A byte transfers on an edge with `pl_valid`&`pl_ready`.
- `busy` in 1: router stall. While high, the current byte is not consumed.
- `err` in 1: router parity-error flag.
- `data_out` out 8: byte to router `data_in`. Registered.
- `pkt_valid` out 1: to router. Registered.
- `done` out 1: one-cycle pulse at packet end.
- `pkt_err` out 1: valid with `done`. High if `err` was seen in the window.
- `bad_cmd` out 1: one-cycle pulse when an illegal command is dropped.

## Operation
- **Header byte:** {len[5:0], addr[1:0]}. Parity is the 8-bit XOR of the header and every payload byte.
- **IDLE**
  - On `start`, latch `req_addr`/`req_len`.
  - If addr==3 or len==0: pulse `bad_cmd` next cycle and stay in IDLE.
  - Otherwise seed parity with the header, clear the counter, go to LOAD.
- **LOAD**
  - Each transfer writes the buffer at index cnt, XORs the byte into parity and increments cnt. Gaps in `pl_valid` are allowed.
  - When byte len-1 transfers, go to HDR and register `data_out`=header, `pkt_valid`=1.
- **HDR**
  - On an edge with `busy`=0: go to PAYLOAD, cnt=0, `data_out`=buf[0].
  - Otherwise hold.
- **PAYLOAD**
  - On an edge with `busy`=0, advance cnt and present buf[cnt+1].
  - After byte len-1 is consumed: `data_out`=parity, `pkt_valid`=0, go to PARITY.
- **PARITY:** on an edge with `busy`=0, go to WAIT_ERR with the window counter=0. `data_out` returns to 0.
- **WAIT_ERR**
  - Sticky-OR `err` into `pkt_err`.
  - After ERR_WAIT cycles, pulse `done` for one cycle, clear `pkt_err` the cycle after, return to IDLE.
- **Stalls:** `data_out` and `pkt_valid` never change on an edge where `busy`=1 during HDR, PAYLOAD or PARITY.
- **`start` outside IDLE:** ignored.
- **`err` outside WAIT_ERR:** ignored.
- **Reset (asynchronous, any state, including mid-packet)**
  - State goes to IDLE.
  - `data_out`=0, `pkt_valid`=0, `done`=0, `pkt_err`=0, `bad_cmd`=0.
  - `pl_ready`=0 and `start_ready`=1.
  - Buffer contents are don't-care.
  - No partial packet resumes after reset.

## Timing
- **Command to LOAD:** command accepted at edge E0; LOAD is active from E0.
- **Header:** appears in the cycle after the edge that takes the last payload byte.
- **Unstalled transmit:** header, len payload bytes and parity occupy len+2 consecutive cycles. `pkt_valid` is high for exactly len+1 of them.
- **Each `busy`=1 edge:** adds one cycle to the current byte.
- **`done`:** asserted ERR_WAIT cycles after the parity byte is consumed.
- **`bad_cmd`:** asserted the cycle after E0; `start_ready` stays 1.
- **Back-to-back commands:** `start_ready` is 1 in the cycle after `done`.

## Structure
- **Shared defines file (same as the router FSM):**
  - TX state encodings: IDLE, LOAD, HDR, PAYLOAD, PARITY, WAIT_ERR.
  - Header field positions: LEN [7:2], ADDR [1:0].
  - Illegal address constant 2'b11.
  - Maximum length 63.
- **Sub-module `router_tx_buf`:** 64x8 storage, synchronous write (we, waddr, wdata), combinational read by raddr.
- **Top level:** FSM, counters and parity register.

## Test plan
1. addr=1, len=3, payload 0x11,0x22,0x33, `busy`=0 → `data_out` 0x0D,0x11,0x22,0x33,0x0D on consecutive cycles; `pkt_valid` 1,1,1,1,0; `done` 3 cycles later with `pkt_err`=0.
2. Same packet with `busy`=1 on the first 2 HDR edges → header held 3 cycles, then payload unstalled.
3. `busy` pulsed once during PAYLOAD and once during PARITY → the affected byte is held exactly one extra cycle.
4. Illegal commands:
   - req_addr=3, len=5 → `bad_cmd` pulse, `pkt_valid` stays 0, `pl_ready` stays 0.
   - len=0 → `bad_cmd` pulse, no packet sent.
5. addr=2, len=63 with random `pl_valid` gaps → 63 bytes transmitted in order; parity equals the reference XOR; header 0xFE.
6. Error and reset:
   - `err`=1 one cycle, 2 cycles after parity is consumed → `done` with `pkt_err`=1.
   - `resetn` low mid-PAYLOAD → `pkt_valid`/`data_out`=0 immediately; `start_ready`=1.

Source files
------------

// File: rtl/router_pkt_tx_pkg.sv
// Shared router TX definitions: state encodings, header field layout and
// the parity helper used by the packet transmitter.
package router_pkt_tx_pkg;

  typedef enum logic [2:0] {
    TX_IDLE     = 3'd0,
    TX_LOAD     = 3'd1,
    TX_HDR      = 3'd2,
    TX_PAYLOAD  = 3'd3,
    TX_PARITY   = 3'd4,
    TX_WAIT_ERR = 3'd5
  } tx_state_t;

  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;

  localparam logic [1:0] ADDR_ILLEGAL = 2'b11;
  localparam int         MAX_LEN      = 63;
  localparam int         BUF_DEPTH    = MAX_LEN + 1;

  function automatic logic [7:0] make_header(input logic [1:0] addr, input logic [5:0] len);
    logic [7:0] h;
    h = 8'd0;
    h[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
    h[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
    return h;
  endfunction

  function automatic logic [7:0] parity_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload staging buffer: synchronous write, combinational read.
module router_tx_buf
  import router_pkt_tx_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [5:0] waddr,
  input  logic [7:0] wdata,
  input  logic [5:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem_r [BUF_DEPTH];

  // Contents are not reset; they are always rewritten before being sent.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router source port: collects a payload, then sends header/payload/parity
// under busy back-pressure and reports the router err flag per packet.
module router_pkt_tx
  import router_pkt_tx_pkg::*;
#(
  parameter int unsigned ERR_WAIT = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] req_addr,
  input  logic [5:0] req_len,
  output logic       start_ready,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic       busy,
  input  logic       err,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       done,
  output logic       pkt_err,
  output logic       bad_cmd
);

  localparam logic [3:0] WAIT_LAST = 4'(ERR_WAIT - 1);

  tx_state_t  state_r, state_s;
  logic [1:0] addr_r, addr_s;
  logic [5:0] len_r, len_s;
  logic [5:0] cnt_r, cnt_s;
  logic [7:0] par_r, par_s;
  logic [3:0] wcnt_r, wcnt_s;
  logic [7:0] data_out_r, data_out_s;
  logic       pkt_valid_r, pkt_valid_s;
  logic       done_r, done_s;
  logic       pkt_err_r, pkt_err_s;
  logic       bad_cmd_r, bad_cmd_s;
  logic       we_s;
  logic [5:0] raddr_s;
  logic [7:0] rdata_s;
  logic [7:0] hdr_s;

  router_tx_buf u_buf (
    .clk   (clk),
    .we    (we_s),
    .waddr (cnt_r),
    .wdata (pl_data),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  assign hdr_s       = make_header(addr_r, len_r);
  assign start_ready = (state_r == TX_IDLE);
  assign pl_ready    = (state_r == TX_LOAD);

  // Next-state and next-register values for the whole transmitter.
  always_comb begin
    state_s     = state_r;
    addr_s      = addr_r;
    len_s       = len_r;
    cnt_s       = cnt_r;
    par_s       = par_r;
    wcnt_s      = wcnt_r;
    data_out_s  = data_out_r;
    pkt_valid_s = pkt_valid_r;
    done_s      = 1'b0;
    bad_cmd_s   = 1'b0;
    we_s        = 1'b0;
    raddr_s     = 6'd0;
    if (done_r) begin
      pkt_err_s = 1'b0;
    end else begin
      pkt_err_s = pkt_err_r;
    end

    case (state_r)
      TX_IDLE: begin
        if (start) begin
          addr_s = req_addr;
          len_s  = req_len;
          if ((req_addr == ADDR_ILLEGAL) || (req_len == 6'd0)) begin
            bad_cmd_s = 1'b1;
          end else begin
            par_s   = make_header(req_addr, req_len);
            cnt_s   = 6'd0;
            state_s = TX_LOAD;
          end
        end else begin
          state_s = TX_IDLE;
        end
      end
      TX_LOAD: begin
        if (pl_valid) begin
          we_s  = 1'b1;
          par_s = parity_step(par_r, pl_data);
          cnt_s = cnt_r + 6'd1;
          if (cnt_r == (len_r - 6'd1)) begin
            state_s     = TX_HDR;
            data_out_s  = hdr_s;
            pkt_valid_s = 1'b1;
          end else begin
            state_s = TX_LOAD;
          end
        end else begin
          state_s = TX_LOAD;
        end
      end
      TX_HDR: begin
        raddr_s = 6'd0;
        if (!busy) begin
          state_s    = TX_PAYLOAD;
          cnt_s      = 6'd0;
          data_out_s = rdata_s;
        end else begin
          state_s = TX_HDR;
        end
      end
      TX_PAYLOAD: begin
        // Look ahead one entry so the next byte is ready on the consuming edge.
        raddr_s = cnt_r + 6'd1;
        if (!busy) begin
          if (cnt_r == (len_r - 6'd1)) begin
            state_s     = TX_PARITY;
            data_out_s  = par_r;
            pkt_valid_s = 1'b0;
          end else begin
            cnt_s      = cnt_r + 6'd1;
            data_out_s = rdata_s;
          end
        end else begin
          state_s = TX_PAYLOAD;
        end
      end
      TX_PARITY: begin
        if (!busy) begin
          state_s    = TX_WAIT_ERR;
          wcnt_s     = 4'd0;
          data_out_s = 8'd0;
        end else begin
          state_s = TX_PARITY;
        end
      end
      TX_WAIT_ERR: begin
        pkt_err_s = pkt_err_r | err;
        wcnt_s    = wcnt_r + 4'd1;
        if (wcnt_r == WAIT_LAST) begin
          done_s  = 1'b1;
          state_s = TX_IDLE;
        end else begin
          state_s = TX_WAIT_ERR;
        end
      end
      default: begin
        state_s     = TX_IDLE;
        data_out_s  = 8'd0;
        pkt_valid_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= TX_IDLE;
      addr_r      <= 2'd0;
      len_r       <= 6'd0;
      cnt_r       <= 6'd0;
      par_r       <= 8'd0;
      wcnt_r      <= 4'd0;
      data_out_r  <= 8'd0;
      pkt_valid_r <= 1'b0;
      done_r      <= 1'b0;
      pkt_err_r   <= 1'b0;
      bad_cmd_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      addr_r      <= addr_s;
      len_r       <= len_s;
      cnt_r       <= cnt_s;
      par_r       <= par_s;
      wcnt_r      <= wcnt_s;
      data_out_r  <= data_out_s;
      pkt_valid_r <= pkt_valid_s;
      done_r      <= done_s;
      pkt_err_r   <= pkt_err_s;
      bad_cmd_r   <= bad_cmd_s;
    end
  end

  assign data_out  = data_out_r;
  assign pkt_valid = pkt_valid_r;
  assign done      = done_r;
  assign pkt_err   = pkt_err_r;
  assign bad_cmd   = bad_cmd_r;

endmodule
